// File: rtl/ebu_pkg.sv
// Shared types for the EBU AHB-Lite arbiter.
package ebu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IFU,
      ARB_LSU
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IFU,
      OWN_LSU
   } owner_t;

endpackage

// File: rtl/ebu_req_capture.sv
// Per-master address-phase capture register and effective-request mux.
// A request that cannot be issued in the cycle it is presented (other master
// owns the address phase, or the bus is waiting) is held here until issued.
module ebu_req_capture
   import ebu_pkg::*;
#(
   parameter int PA_BITS = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PA_BITS-1:0] haddr_i,
   input  logic [1:0]         htrans_i,
   input  logic               hwrite_i,
   input  logic [2:0]         hsize_i,
   input  logic               issue_i,     // this master owns the address phase now
   input  logic               hready_i,
   output logic               valid_o,
   output logic [PA_BITS-1:0] haddr_o,
   output logic [1:0]         htrans_o,
   output logic               hwrite_o,
   output logic [2:0]         hsize_o
);

   logic               valid_q, valid_d;
   logic [PA_BITS-1:0] haddr_q;
   logic [1:0]         htrans_q;
   logic               hwrite_q;
   logic [2:0]         hsize_q;
   logic               load;

   // Only an empty entry loads; a stalled master holds its live inputs anyway.
   assign load = !valid_q && (htrans_i != IDLE) && (!issue_i || !hready_i);

   // Entry valid: set on load, cleared once the captured transfer is accepted.
   always_comb begin
      valid_d = valid_q;
      if (load)
         valid_d = 1'b1;
      else if (valid_q && issue_i && hready_i)
         valid_d = 1'b0;
   end

   // Capture storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         haddr_q  <= '0;
         htrans_q <= IDLE;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            haddr_q  <= haddr_i;
            htrans_q <= htrans_i;
            hwrite_q <= hwrite_i;
            hsize_q  <= hsize_i;
         end
      end
   end

   assign valid_o  = valid_q;
   assign haddr_o  = valid_q ? haddr_q  : haddr_i;
   assign htrans_o = valid_q ? htrans_q : htrans_i;
   assign hwrite_o = valid_q ? hwrite_q : hwrite_i;
   assign hsize_o  = valid_q ? hsize_q  : hsize_i;

endmodule

// File: rtl/ebu_ahb_arbiter.sv
// Two-master (IFU/LSU) AHB-Lite arbiter onto a single external AHB port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARB_IDLE | no master owned the last accepted address phase
// ARB_IFU  | IFU owned the last address phase (held through SEQ beats)
// ARB_LSU  | LSU owned the last address phase (held through SEQ beats)
//
// The current address-phase owner (grant) is combinational so an uncontended
// request issues with zero added latency. While HREADY=0 the owner is frozen,
// and an owner whose own request got captured during a wait keeps the bus
// until that request is accepted, so a waited address never changes.
module ebu_ahb_arbiter
   import ebu_pkg::*;
#(
   parameter int PA_BITS      = 32,
   parameter int XLEN         = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic [PA_BITS-1:0]  IFUHADDR,
   input  logic [1:0]          IFUHTRANS,
   input  logic [2:0]          IFUHSIZE,
   output logic                IFUHREADY,
   input  logic [PA_BITS-1:0]  LSUHADDR,
   input  logic [1:0]          LSUHTRANS,
   input  logic                LSUHWRITE,
   input  logic [2:0]          LSUHSIZE,
   input  logic [XLEN-1:0]     LSUHWDATA,
   input  logic [XLEN/8-1:0]   LSUHWSTRB,
   output logic                LSUHREADY,
   output logic [PA_BITS-1:0]  HADDR,
   output logic [1:0]          HTRANS,
   output logic                HWRITE,
   output logic [2:0]          HSIZE,
   output logic [XLEN-1:0]     HWDATA,
   output logic [XLEN/8-1:0]   HWSTRB,
   input  logic                HREADY,
   output logic                GrantLSU
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_t         state_q, grant;
   owner_t             dph_q, grant_own;
   logic [CW-1:0]      starve_q, starve_d;
   logic               starve_max;

   logic               ifu_vld, lsu_vld;
   logic [PA_BITS-1:0] ifu_addr, lsu_addr;
   logic [1:0]         ifu_trans, lsu_trans;
   logic               ifu_write, lsu_write;
   logic [2:0]         ifu_size, lsu_size;
   logic               ifu_req, lsu_req;

   ebu_req_capture #(.PA_BITS(PA_BITS)) u_ifu_cap (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .haddr_i  (IFUHADDR),
      .htrans_i (IFUHTRANS),
      .hwrite_i (1'b0),
      .hsize_i  (IFUHSIZE),
      .issue_i  (grant == ARB_IFU),
      .hready_i (HREADY),
      .valid_o  (ifu_vld),
      .haddr_o  (ifu_addr),
      .htrans_o (ifu_trans),
      .hwrite_o (ifu_write),
      .hsize_o  (ifu_size)
   );

   ebu_req_capture #(.PA_BITS(PA_BITS)) u_lsu_cap (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .haddr_i  (LSUHADDR),
      .htrans_i (LSUHTRANS),
      .hwrite_i (LSUHWRITE),
      .hsize_i  (LSUHSIZE),
      .issue_i  (grant == ARB_LSU),
      .hready_i (HREADY),
      .valid_o  (lsu_vld),
      .haddr_o  (lsu_addr),
      .htrans_o (lsu_trans),
      .hwrite_o (lsu_write),
      .hsize_o  (lsu_size)
   );

   assign ifu_req    = (ifu_trans != IDLE);
   assign lsu_req    = (lsu_trans != IDLE);
   assign starve_max = (starve_q == CW'(STARVE_LIMIT));

   // Address-phase owner: freeze on wait, hold bursts, else LSU priority with IFU anti-starvation.
   always_comb begin
      grant = ARB_IDLE;
      if (!HRESETn)
         grant = ARB_IDLE;
      else if (!HREADY)
         grant = state_q;
      else if (state_q == ARB_IFU && (ifu_trans == SEQ || ifu_vld))
         grant = ARB_IFU;
      else if (state_q == ARB_LSU && (lsu_trans == SEQ || lsu_vld))
         grant = ARB_LSU;
      else if (lsu_req && !(ifu_req && starve_max))
         grant = ARB_LSU;
      else if (ifu_req)
         grant = ARB_IFU;
   end

   // Starve counter: counts LSU wins while IFU waits, saturating at the limit.
   always_comb begin
      starve_d = starve_q;
      if (!ifu_req)
         starve_d = '0;
      else if (HREADY) begin
         if (grant == ARB_IFU)
            starve_d = '0;
         else if (grant == ARB_LSU && !starve_max)
            starve_d = starve_q + 1'b1;
      end
   end

   // Map the address-phase grant onto the data-phase owner encoding.
   always_comb begin
      case (grant)
         ARB_IFU: grant_own = OWN_IFU;
         ARB_LSU: grant_own = OWN_LSU;
         default: grant_own = OWN_NONE;
      endcase
   end

   // Arbiter FSM, starve counter and data-phase owner; all advance only on HREADY=1.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ARB_IDLE;
         dph_q    <= OWN_NONE;
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
         if (HREADY) begin
            state_q <= grant;
            dph_q   <= (HTRANS != IDLE) ? grant_own : OWN_NONE;
         end
      end
   end

   // Address-phase bus mux from the owner's effective request.
   always_comb begin
      HADDR  = '0;
      HTRANS = IDLE;
      HWRITE = 1'b0;
      HSIZE  = '0;
      case (grant)
         ARB_IFU: begin
            HADDR  = ifu_addr;
            HTRANS = ifu_trans;
            HWRITE = ifu_write;
            HSIZE  = ifu_size;
         end
         ARB_LSU: begin
            HADDR  = lsu_addr;
            HTRANS = lsu_trans;
            HWRITE = lsu_write;
            HSIZE  = lsu_size;
         end
         default: ;
      endcase
   end

   assign GrantLSU  = (grant == ARB_LSU);
   assign HWDATA    = (dph_q == OWN_LSU) ? LSUHWDATA : '0;
   assign HWSTRB    = (dph_q == OWN_LSU) ? LSUHWSTRB : '0;

   assign IFUHREADY = (dph_q == OWN_IFU) ? HREADY : !ifu_vld;
   assign LSUHREADY = (dph_q == OWN_LSU) ? HREADY : !lsu_vld;

endmodule

// File: tb/tb_ebu_ahb_arbiter.sv
// Directed bench for ebu_ahb_arbiter with an expected-value scoreboard.
module tb_ebu_ahb_arbiter;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSQ  = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   logic        HCLK, HRESETn;
   logic [31:0] IFUHADDR, LSUHADDR, HADDR;
   logic [1:0]  IFUHTRANS, LSUHTRANS, HTRANS;
   logic [2:0]  IFUHSIZE, LSUHSIZE, HSIZE;
   logic        IFUHREADY, LSUHREADY, LSUHWRITE, HWRITE, HREADY, GrantLSU;
   logic [63:0] LSUHWDATA, HWDATA;
   logic [7:0]  LSUHWSTRB, HWSTRB;

   ebu_ahb_arbiter #(.PA_BITS(32), .XLEN(64), .STARVE_LIMIT(4)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .IFUHADDR  (IFUHADDR),
      .IFUHTRANS (IFUHTRANS),
      .IFUHSIZE  (IFUHSIZE),
      .IFUHREADY (IFUHREADY),
      .LSUHADDR  (LSUHADDR),
      .LSUHTRANS (LSUHTRANS),
      .LSUHWRITE (LSUHWRITE),
      .LSUHSIZE  (LSUHSIZE),
      .LSUHWDATA (LSUHWDATA),
      .LSUHWSTRB (LSUHWSTRB),
      .LSUHREADY (LSUHREADY),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HWSTRB    (HWSTRB),
      .HREADY    (HREADY),
      .GrantLSU  (GrantLSU)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      string       sig;
      logic [63:0] val;
      int          step;
   } exp_t;

   exp_t sb[$];
   int   tests   = 0;
   int   fails   = 0;
   int   step_no = 0;

   function automatic logic [63:0] obs(input string s);
      case (s)
         "HADDR":     obs = 64'(HADDR);
         "HTRANS":    obs = 64'(HTRANS);
         "HWRITE":    obs = 64'(HWRITE);
         "HSIZE":     obs = 64'(HSIZE);
         "HWDATA":    obs = HWDATA;
         "HWSTRB":    obs = 64'(HWSTRB);
         "IFUHREADY": obs = 64'(IFUHREADY);
         "LSUHREADY": obs = 64'(LSUHREADY);
         "GrantLSU":  obs = 64'(GrantLSU);
         default:     obs = 'x;
      endcase
   endfunction

   task automatic ex(input string s, input logic [63:0] v);
      exp_t e;
      e.sig  = s;
      e.val  = v;
      e.step = step_no;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [63:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.sig);
         tests++;
         assert (o === e.val)
         else begin
            fails++;
            $error("FAIL %s step %0d: observed %0h expected %0h", e.sig, e.step, o, e.val);
         end
      end
   endtask

   task automatic at_next();
      @(posedge HCLK);
      #1;
      step_no++;
   endtask

   task automatic set_idle();
      IFUHADDR  = '0;
      IFUHTRANS = T_IDLE;
      IFUHSIZE  = '0;
      LSUHADDR  = '0;
      LSUHTRANS = T_IDLE;
      LSUHWRITE = 1'b0;
      LSUHSIZE  = '0;
      LSUHWDATA = '0;
      LSUHWSTRB = '0;
   endtask

   task automatic idle_cycle();
      at_next();
      set_idle();
   endtask

   task automatic ifu_drive(input logic [1:0] t, input logic [31:0] a);
      IFUHTRANS = t;
      IFUHADDR  = a;
      IFUHSIZE  = 3'd2;
   endtask

   task automatic lsu_drive(input logic [1:0] t, input logic [31:0] a, input logic w);
      LSUHTRANS = t;
      LSUHADDR  = a;
      LSUHWRITE = w;
      LSUHSIZE  = 3'd3;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset held with live requests present: outputs must still be at reset values.
      HRESETn = 1'b0;
      HREADY  = 1'b1;
      set_idle();
      ifu_drive(T_NSQ, 32'h8000_0000);
      lsu_drive(T_NSQ, 32'h0000_1000, 1'b1);
      LSUHWDATA = '1;
      LSUHWSTRB = '1;
      #2;
      ex("HTRANS", 0); ex("HADDR", 0); ex("HWRITE", 0); ex("HSIZE", 0);
      ex("HWDATA", 0); ex("HWSTRB", 0); ex("IFUHREADY", 1); ex("LSUHREADY", 1);
      ex("GrantLSU", 0);
      check_all();
      set_idle();
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // Lone IFU NONSEQ issues in the same cycle.
      at_next();
      ifu_drive(T_NSQ, 32'h8000_0000);
      ex("HTRANS", 2); ex("HADDR", 64'h8000_0000); ex("GrantLSU", 0);
      ex("IFUHREADY", 1); ex("HWRITE", 0); ex("HSIZE", 2);
      @(negedge HCLK); check_all();
      at_next();
      set_idle();
      ex("HTRANS", 0); ex("IFUHREADY", 1);
      @(negedge HCLK); check_all();
      idle_cycle();

      // Simultaneous NONSEQ: LSU wins, IFU captured and issued next cycle.
      at_next();
      ifu_drive(T_NSQ, 32'h8000_0040);
      lsu_drive(T_NSQ, 32'h0000_1000, 1'b1);
      ex("GrantLSU", 1); ex("HADDR", 64'h1000); ex("HTRANS", 2); ex("HWRITE", 1);
      ex("IFUHREADY", 1); ex("LSUHREADY", 1);
      @(negedge HCLK); check_all();
      at_next();
      set_idle();                           // IFU withdrawal is ignored
      LSUHWDATA = 64'h1122_3344_5566_7788;
      LSUHWSTRB = 8'hFF;
      ex("GrantLSU", 0); ex("HTRANS", 2); ex("HADDR", 64'h8000_0040); ex("HWRITE", 0);
      ex("HWDATA", 64'h1122_3344_5566_7788); ex("HWSTRB", 64'hFF);
      ex("IFUHREADY", 0); ex("LSUHREADY", 1);
      @(negedge HCLK); check_all();
      at_next();
      set_idle();
      LSUHWDATA = 64'hDEAD_BEEF_0000_0001;
      LSUHWSTRB = 8'h0F;
      ex("HWDATA", 0); ex("HWSTRB", 0); ex("IFUHREADY", 1); ex("HTRANS", 0);
      @(negedge HCLK); check_all();
      idle_cycle();

      // Starvation: IFU pending, LSU every cycle; IFU wins on the 5th arbitration.
      for (int k = 0; k < 4; k++) begin
         at_next();
         ifu_drive(T_NSQ, 32'h8000_0100);
         lsu_drive(T_NSQ, 32'h2000 + 32'(8 * k), 1'b0);
         ex("GrantLSU", 1); ex("HADDR", 64'h2000 + 64'(8 * k));
         if (k >= 1) ex("IFUHREADY", 0);
         @(negedge HCLK); check_all();
      end
      at_next();
      lsu_drive(T_NSQ, 32'h2020, 1'b0);
      ex("GrantLSU", 0); ex("HADDR", 64'h8000_0100); ex("HTRANS", 2); ex("IFUHREADY", 0);
      @(negedge HCLK); check_all();
      at_next();
      ifu_drive(T_IDLE, 32'h0);
      lsu_drive(T_NSQ, 32'h2028, 1'b0);
      ex("GrantLSU", 1); ex("HADDR", 64'h2020); ex("LSUHREADY", 0); ex("IFUHREADY", 1);
      @(negedge HCLK); check_all();
      at_next();
      ex("HADDR", 64'h2028); ex("LSUHREADY", 1); ex("GrantLSU", 1);
      @(negedge HCLK); check_all();
      idle_cycle();
      idle_cycle();

      // IFU 4-beat burst; LSU arrives at beat 2 and waits for the burst to end.
      at_next();
      ifu_drive(T_NSQ, 32'h8000_0200);
      ex("HADDR", 64'h8000_0200); ex("GrantLSU", 0);
      @(negedge HCLK); check_all();
      at_next();
      ifu_drive(T_SEQ, 32'h8000_0204);
      lsu_drive(T_NSQ, 32'h3000, 1'b0);
      ex("HADDR", 64'h8000_0204); ex("HTRANS", 3); ex("GrantLSU", 0); ex("LSUHREADY", 1);
      @(negedge HCLK); check_all();
      at_next();
      ifu_drive(T_SEQ, 32'h8000_0208);
      lsu_drive(T_IDLE, 32'h0, 1'b0);
      ex("HADDR", 64'h8000_0208); ex("GrantLSU", 0); ex("LSUHREADY", 0);
      @(negedge HCLK); check_all();
      at_next();
      ifu_drive(T_SEQ, 32'h8000_020C);
      ex("HADDR", 64'h8000_020C); ex("GrantLSU", 0); ex("LSUHREADY", 0);
      @(negedge HCLK); check_all();
      at_next();
      ifu_drive(T_IDLE, 32'h0);
      ex("HADDR", 64'h3000); ex("HTRANS", 2); ex("GrantLSU", 1); ex("LSUHREADY", 0);
      @(negedge HCLK); check_all();
      at_next();
      ex("HTRANS", 0); ex("LSUHREADY", 1);
      @(negedge HCLK); check_all();
      idle_cycle();

      // LSU data phase waited 3 cycles; pipelined next address must stay stable.
      at_next();
      lsu_drive(T_NSQ, 32'h4000, 1'b1);
      ex("HADDR", 64'h4000); ex("GrantLSU", 1);
      @(negedge HCLK); check_all();
      for (int w = 0; w < 3; w++) begin
         at_next();
         HREADY = 1'b0;
         lsu_drive(T_NSQ, 32'h4008, 1'b1);
         LSUHWDATA = 64'hA5A5_0000_0000_4000;
         LSUHWSTRB = 8'hF0;
         ex("LSUHREADY", 0); ex("HTRANS", 2); ex("HADDR", 64'h4008); ex("GrantLSU", 1);
         ex("HWDATA", 64'hA5A5_0000_0000_4000);
         @(negedge HCLK); check_all();
      end
      at_next();
      HREADY = 1'b1;
      ex("HADDR", 64'h4008); ex("HTRANS", 2); ex("LSUHREADY", 1); ex("HWSTRB", 64'hF0);
      @(negedge HCLK); check_all();
      at_next();
      set_idle();
      LSUHWDATA = 64'h5A5A_0000_0000_4008;
      ex("HWDATA", 64'h5A5A_0000_0000_4008); ex("LSUHREADY", 1); ex("HTRANS", 0);
      @(negedge HCLK); check_all();
      idle_cycle();

      // Reset asserted mid-transfer with an IFU request captured.
      at_next();
      ifu_drive(T_NSQ, 32'h8000_0300);
      lsu_drive(T_NSQ, 32'h5000, 1'b1);
      ex("GrantLSU", 1); ex("HADDR", 64'h5000);
      @(negedge HCLK); check_all();
      at_next();
      lsu_drive(T_IDLE, 32'h0, 1'b0);
      LSUHWDATA = 64'hCAFE;
      LSUHWSTRB = 8'h3C;
      ex("GrantLSU", 0); ex("HADDR", 64'h8000_0300); ex("IFUHREADY", 0);
      ex("HWDATA", 64'hCAFE);
      @(negedge HCLK); check_all();
      #1;
      HRESETn = 1'b0;
      lsu_drive(T_NSQ, 32'h5008, 1'b1);
      #1;
      step_no++;
      ex("HTRANS", 0); ex("HADDR", 0); ex("HWRITE", 0); ex("GrantLSU", 0);
      ex("HWDATA", 0); ex("HWSTRB", 0); ex("IFUHREADY", 1); ex("LSUHREADY", 1);
      check_all();
      set_idle();
      at_next();
      HRESETn = 1'b1;
      ex("HTRANS", 0); ex("IFUHREADY", 1); ex("LSUHREADY", 1);
      @(negedge HCLK); check_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
